// File: rtl/auth_sequencer_pkg.sv
// Shared request codes, verdict fail codes and one-hot FSM encodings for the
// authentication sequencer and its timers.
package auth_sequencer_pkg;

  localparam logic [1:0] REQ_NONE        = 2'd0;
  localparam logic [1:0] REQ_CHALLENGE   = 2'd1;
  localparam logic [1:0] REQ_DIGESTS     = 2'd2;
  localparam logic [1:0] REQ_CERTIFICATE = 2'd3;

  localparam logic [2:0] FAIL_NONE        = 3'd0;
  localparam logic [2:0] FAIL_DIGEST_TMO  = 3'd1;
  localparam logic [2:0] FAIL_CERT_TMO    = 3'd2;
  localparam logic [2:0] FAIL_CHAL_TMO    = 3'd3;
  localparam logic [2:0] FAIL_CERT_FAILED = 3'd4;
  localparam logic [2:0] FAIL_ABORT       = 3'd5;
  localparam logic [2:0] FAIL_HS_TMO      = 3'd6;

  localparam int SIZE_OF_STATES_SEQ = 7;

  typedef enum logic [SIZE_OF_STATES_SEQ-1:0] {
    S_IDLE      = 7'b000_0001,
    S_ISSUE     = 7'b000_0010,
    S_WAIT_SENT = 7'b000_0100,
    S_RELEASE   = 7'b000_1000,
    S_WAIT_RESP = 7'b001_0000,
    S_PASS      = 7'b010_0000,
    S_FAIL      = 7'b100_0000
  } state_e;

  function automatic logic [1:0] next_step(input logic [1:0] step);
    case (step)
      REQ_DIGESTS:     next_step = REQ_CERTIFICATE;
      REQ_CERTIFICATE: next_step = REQ_CHALLENGE;
      default:         next_step = REQ_NONE;
    endcase
  endfunction

  function automatic logic [2:0] timeout_code(input logic [1:0] step);
    case (step)
      REQ_DIGESTS:     timeout_code = FAIL_DIGEST_TMO;
      REQ_CERTIFICATE: timeout_code = FAIL_CERT_TMO;
      default:         timeout_code = FAIL_CHAL_TMO;
    endcase
  endfunction

endpackage

// File: rtl/auth_timer.sv
// Loadable down-counter; expired_o flags the enabled cycle in which the count
// runs out, so a load of N gives exactly N enabled cycles.
module auth_timer #(
  parameter int TMR_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load_i,
  input  logic [TMR_W-1:0] load_val_i,
  input  logic             en_i,
  output logic             expired_o
);

  logic [TMR_W-1:0] cnt_d;
  logic [TMR_W-1:0] cnt_q;

  // next count: load wins over decrement, count saturates at zero
  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (en_i && (cnt_q != {TMR_W{1'b0}})) begin
      cnt_d = cnt_q - {{(TMR_W-1){1'b0}}, 1'b1};
    end else begin
      cnt_d = cnt_q;
    end
  end

  // count register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q <= {TMR_W{1'b0}};
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expired_o = en_i && (cnt_q <= {{(TMR_W-1){1'b0}}, 1'b1});

endmodule

// File: rtl/auth_sequencer.sv
// Walks the initiator through DIGESTS -> CERTIFICATE -> CHALLENGE with
// per-step retries and reports one pass/fail verdict with a fail code.
module auth_sequencer
  import auth_sequencer_pkg::*;
#(
  parameter int MAX_RETRIES = 2,
  parameter int HS_TIMEOUT  = 64,
  parameter int TMR_W       = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       slot_sel,
  input  logic             abort,
  input  logic             init_ack_out,
  input  logic [TMR_W-1:0] current_timeout,
  input  logic             resp_valid,
  input  logic             cert_done,
  input  logic             cert_failed,
  output logic             init_req,
  output logic [1:0]       type_of_request,
  output logic [1:0]       slot,
  output logic             init_ack_in,
  output logic             error_busy,
  output logic             busy,
  output logic             auth_pass,
  output logic             auth_fail,
  output logic [2:0]       fail_code,
  output logic [2:0]       retry_count
);

  localparam logic [2:0]       MAX_R   = 3'(MAX_RETRIES);
  localparam logic [TMR_W-1:0] HS_LOAD = TMR_W'(HS_TIMEOUT);

  state_e     state_d, state_q;
  logic [1:0] step_d, step_q;
  logic [1:0] slot_d, slot_q;
  logic [2:0] retry_d, retry_q;
  logic [2:0] code_d, code_q;
  logic       pass_d, pass_q;
  logic       fail_d, fail_q;
  logic       req_d, req_q;
  logic [1:0] type_d, type_q;
  logic       ack_in_d, ack_in_q;
  logic       err_d, err_q;
  logic       busy_d, busy_q;

  logic             active_s;
  logic             resp_hit_s;
  logic             hs_expired_s;
  logic             rsp_expired_s;
  logic [TMR_W-1:0] rsp_load_val_s;

  // a zero timeout from the initiator still gets one cycle to answer
  assign rsp_load_val_s = (current_timeout == {TMR_W{1'b0}}) ?
                          {{(TMR_W-1){1'b0}}, 1'b1} : current_timeout;

  auth_timer #(.TMR_W(TMR_W)) u_hs_timer (
    .clk        (clk),
    .reset      (reset),
    .load_i     (state_q == S_ISSUE),
    .load_val_i (HS_LOAD),
    .en_i       (state_q == S_WAIT_SENT),
    .expired_o  (hs_expired_s)
  );

  auth_timer #(.TMR_W(TMR_W)) u_rsp_timer (
    .clk        (clk),
    .reset      (reset),
    .load_i     (state_q == S_RELEASE),
    .load_val_i (rsp_load_val_s),
    .en_i       (state_q == S_WAIT_RESP),
    .expired_o  (rsp_expired_s)
  );

  // next state, step bookkeeping and next values of every registered output
  always_comb begin
    state_d    = state_q;
    step_d     = step_q;
    slot_d     = slot_q;
    retry_d    = retry_q;
    code_d     = code_q;
    pass_d     = pass_q;
    fail_d     = fail_q;
    active_s   = (state_q == S_ISSUE) || (state_q == S_WAIT_SENT) ||
                 (state_q == S_RELEASE) || (state_q == S_WAIT_RESP);
    resp_hit_s = (step_q == REQ_CERTIFICATE) ? cert_done : resp_valid;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_ISSUE;
          step_d  = REQ_DIGESTS;
          slot_d  = slot_sel;
          retry_d = 3'd0;
          code_d  = FAIL_NONE;
          pass_d  = 1'b0;
          fail_d  = 1'b0;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_ISSUE: state_d = S_WAIT_SENT;
      S_WAIT_SENT: begin
        if (init_ack_out) begin
          state_d = S_RELEASE;
        end else if (hs_expired_s) begin
          state_d = S_FAIL;
          code_d  = FAIL_HS_TMO;
        end else begin
          state_d = S_WAIT_SENT;
        end
      end
      S_RELEASE: state_d = S_WAIT_RESP;
      S_WAIT_RESP: begin
        if (resp_hit_s) begin
          if (step_q == REQ_CHALLENGE) begin
            state_d = S_PASS;
          end else begin
            state_d = S_ISSUE;
            step_d  = next_step(step_q);
            retry_d = 3'd0;
          end
        end else if (rsp_expired_s) begin
          if (retry_q < MAX_R) begin
            state_d = S_ISSUE;
            retry_d = retry_q + 3'd1;
          end else begin
            state_d = S_FAIL;
            code_d  = timeout_code(step_q);
          end
        end else begin
          state_d = S_WAIT_RESP;
        end
      end
      S_PASS:  state_d = S_IDLE;
      S_FAIL:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    if (active_s && abort) begin
      state_d = S_FAIL;
      code_d  = FAIL_ABORT;
    end else if (active_s && cert_failed) begin
      state_d = S_FAIL;
      code_d  = FAIL_CERT_FAILED;
    end else begin
      code_d = code_d;
    end

    if (state_d == S_PASS) begin
      pass_d = 1'b1;
    end else if (state_d == S_FAIL) begin
      fail_d = 1'b1;
    end else begin
      pass_d = pass_d;
    end

    req_d    = (state_d == S_ISSUE);
    ack_in_d = (state_d == S_RELEASE);
    err_d    = (state_d == S_FAIL);
    busy_d   = (state_d == S_ISSUE) || (state_d == S_WAIT_SENT) ||
               (state_d == S_RELEASE) || (state_d == S_WAIT_RESP);
    type_d   = busy_d ? step_d : REQ_NONE;
  end

  // FSM and output registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= S_IDLE;
      step_q   <= REQ_NONE;
      slot_q   <= 2'd0;
      retry_q  <= 3'd0;
      code_q   <= FAIL_NONE;
      pass_q   <= 1'b0;
      fail_q   <= 1'b0;
      req_q    <= 1'b0;
      type_q   <= REQ_NONE;
      ack_in_q <= 1'b0;
      err_q    <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      step_q   <= step_d;
      slot_q   <= slot_d;
      retry_q  <= retry_d;
      code_q   <= code_d;
      pass_q   <= pass_d;
      fail_q   <= fail_d;
      req_q    <= req_d;
      type_q   <= type_d;
      ack_in_q <= ack_in_d;
      err_q    <= err_d;
      busy_q   <= busy_d;
    end
  end

  assign init_req        = req_q;
  assign type_of_request = type_q;
  assign slot            = slot_q;
  assign init_ack_in     = ack_in_q;
  assign error_busy      = err_q;
  assign busy            = busy_q;
  assign auth_pass       = pass_q;
  assign auth_fail       = fail_q;
  assign fail_code       = code_q;
  assign retry_count     = retry_q;

endmodule

// File: tb/tb_auth_sequencer.sv
// Scoreboard bench for auth_sequencer: directed flows push expected requests
// and verdicts; a negedge monitor pops and compares them as the DUT shows them.
module tb_auth_sequencer;

  localparam int TMR_W  = 32;
  localparam int K_NONE = 0;
  localparam int K_RESP = 1;
  localparam int K_CERT = 2;

  typedef struct {
    logic [1:0] typ;
    logic [1:0] slt;
    logic [2:0] rty;
  } req_t;

  typedef struct {
    logic       p;
    logic       f;
    logic [2:0] code;
  } verdict_t;

  logic             clk = 1'b0;
  logic             reset = 1'b0;
  logic             start = 1'b0;
  logic [1:0]       slot_sel = 2'd0;
  logic             abort = 1'b0;
  logic             init_ack_out = 1'b0;
  logic [TMR_W-1:0] current_timeout = 32'd100;
  logic             resp_valid = 1'b0;
  logic             cert_done = 1'b0;
  logic             cert_failed = 1'b0;
  logic             init_req;
  logic [1:0]       type_of_request;
  logic [1:0]       slot;
  logic             init_ack_in;
  logic             error_busy;
  logic             busy;
  logic             auth_pass;
  logic             auth_fail;
  logic [2:0]       fail_code;
  logic [2:0]       retry_count;

  req_t     req_q[$];
  verdict_t verdict_q[$];
  int       checks = 0;
  int       failures = 0;
  int       ack_cnt = 0;
  int       eb_cnt = 0;
  logic [1:0] cur_slot = 2'd0;

  auth_sequencer #(.MAX_RETRIES(2), .HS_TIMEOUT(64), .TMR_W(TMR_W)) dut (
    .clk(clk), .reset(reset), .start(start), .slot_sel(slot_sel), .abort(abort),
    .init_ack_out(init_ack_out), .current_timeout(current_timeout),
    .resp_valid(resp_valid), .cert_done(cert_done), .cert_failed(cert_failed),
    .init_req(init_req), .type_of_request(type_of_request), .slot(slot),
    .init_ack_in(init_ack_in), .error_busy(error_busy), .busy(busy),
    .auth_pass(auth_pass), .auth_fail(auth_fail), .fail_code(fail_code),
    .retry_count(retry_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  task automatic push_req(input logic [1:0] t, input logic [1:0] s, input logic [2:0] r);
    req_t e;
    e.typ = t; e.slt = s; e.rty = r;
    req_q.push_back(e);
  endtask

  task automatic push_verdict(input logic p, input logic f, input logic [2:0] c);
    verdict_t e;
    e.p = p; e.f = f; e.code = c;
    verdict_q.push_back(e);
  endtask

  task automatic start_flow(input logic [1:0] s);
    push_req(2'd2, s, 3'd0);
    cur_slot = s;
    slot_sel = s;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_req(output int n);
    n = 0;
    while (!init_req && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("req_seen", int'(init_req), 1);
  endtask

  task automatic wait_verdict(input int bound);
    int n;
    n = 0;
    while (!(auth_pass || auth_fail) && n < bound) begin
      @(negedge clk);
      n++;
    end
    check("verdict_seen", int'(auth_pass || auth_fail), 1);
  endtask

  // called at a negedge showing init_req; acks, then optionally answers
  task automatic serve(input int ack_dly, input int rsp_dly, input int kind);
    repeat (ack_dly) @(negedge clk);
    init_ack_out = 1'b1;
    @(negedge clk);
    init_ack_out = 1'b0;
    if (kind != K_NONE) begin
      repeat (rsp_dly) @(negedge clk);
      if (kind == K_RESP) resp_valid = 1'b1;
      else cert_done = 1'b1;
      @(negedge clk);
      resp_valid = 1'b0;
      cert_done  = 1'b0;
    end
  endtask

  task automatic step_ok(input logic [1:0] next_typ, input int kind);
    int n;
    wait_req(n);
    push_req(next_typ, cur_slot, 3'd0);
    serve(2, 2, kind);
  endtask

  task automatic final_ok(input int kind);
    int n;
    wait_req(n);
    push_verdict(1'b1, 1'b0, 3'd0);
    serve(2, 2, kind);
    check("pass_latency", int'(auth_pass), 1);
  endtask

  // scoreboard monitor
  initial begin
    logic     v_prev;
    req_t     r;
    verdict_t v;
    v_prev = 1'b0;
    forever begin
      @(negedge clk);
      if (init_req) begin
        if (req_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL req_unexpected type=%0d slot=%0d retry=%0d", type_of_request, slot, retry_count);
        end else begin
          r = req_q.pop_front();
          check("req_type", int'(type_of_request), int'(r.typ));
          check("req_slot", int'(slot), int'(r.slt));
          check("req_retry", int'(retry_count), int'(r.rty));
        end
      end
      if ((auth_pass || auth_fail) && !v_prev) begin
        if (verdict_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL verdict_unexpected pass=%0d fail=%0d code=%0d", auth_pass, auth_fail, fail_code);
        end else begin
          v = verdict_q.pop_front();
          check("verdict_pass", int'(auth_pass), int'(v.p));
          check("verdict_fail", int'(auth_fail), int'(v.f));
          check("verdict_code", int'(fail_code), int'(v.code));
          check("verdict_busy", int'(busy), 0);
        end
      end
      v_prev = auth_pass || auth_fail;
      if (init_ack_in) ack_cnt++;
      if (error_busy) eb_cnt++;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int ack0;
    int eb0;
    repeat (2) @(negedge clk);
    check("reset_outputs", int'({init_req, type_of_request, slot, init_ack_in, error_busy,
          busy, auth_pass, auth_fail, fail_code, retry_count}), 0);
    reset = 1'b1;
    repeat (2) @(negedge clk);

    // happy path: slot 2, ack after 3 cycles, replies after 10
    ack0 = ack_cnt;
    current_timeout = 32'd100;
    start_flow(2'd2);
    check("start_latency", int'(init_req), 1);
    check("busy_after_start", int'(busy), 1);
    wait_req(n);
    push_req(2'd3, 2'd2, 3'd0);
    serve(3, 10, K_RESP);
    wait_req(n);
    push_req(2'd1, 2'd2, 3'd0);
    serve(3, 10, K_CERT);
    wait_req(n);
    push_verdict(1'b1, 1'b0, 3'd0);
    serve(3, 10, K_RESP);
    check("pass_latency", int'(auth_pass), 1);
    check("happy_fail_code", int'(fail_code), 0);
    check("happy_slot", int'(slot), 2);
    check("happy_ack_in_pulses", ack_cnt - ack0, 3);
    repeat (3) @(negedge clk);

    // retry: first DIGESTS unanswered, reissued after the 5-cycle timeout
    current_timeout = 32'd5;
    start_flow(2'd1);
    wait_req(n);
    serve(2, 0, K_NONE);
    push_req(2'd2, 2'd1, 3'd1);
    wait_req(n);
    check("retry_reissue_gap", n, 6);
    push_req(2'd3, 2'd1, 3'd0);
    serve(2, 2, K_RESP);
    step_ok(2'd1, K_CERT);
    final_ok(K_RESP);
    repeat (3) @(negedge clk);

    // exhaustion: CHALLENGE never answered
    eb0 = eb_cnt;
    start_flow(2'd0);
    step_ok(2'd3, K_RESP);
    step_ok(2'd1, K_CERT);
    wait_req(n);
    push_req(2'd1, 2'd0, 3'd1);
    serve(2, 0, K_NONE);
    wait_req(n);
    push_req(2'd1, 2'd0, 3'd2);
    serve(2, 0, K_NONE);
    wait_req(n);
    push_verdict(1'b0, 1'b1, 3'd3);
    serve(2, 0, K_NONE);
    wait_verdict(20);
    repeat (2) @(negedge clk);
    check("exhaust_error_busy_pulses", eb_cnt - eb0, 1);
    repeat (2) @(negedge clk);

    // cert_failed during CERTIFICATE wait
    eb0 = eb_cnt;
    current_timeout = 32'd100;
    start_flow(2'd3);
    step_ok(2'd3, K_RESP);
    wait_req(n);
    serve(1, 0, K_NONE);
    @(negedge clk);
    push_verdict(1'b0, 1'b1, 3'd4);
    cert_failed = 1'b1;
    @(negedge clk);
    cert_failed = 1'b0;
    check("certfail_latency", int'(auth_fail), 1);
    check("certfail_code", int'(fail_code), 4);
    @(negedge clk);
    check("certfail_error_busy", eb_cnt - eb0, 1);

    // restart, reply in the expiry cycle, then abort + cert_failed together
    current_timeout = 32'd5;
    start_flow(2'd0);
    check("restart_clears_fail", int'(auth_fail), 0);
    check("restart_clears_code", int'(fail_code), 0);
    push_req(2'd3, 2'd0, 3'd0);
    serve(1, 5, K_RESP);
    push_verdict(1'b0, 1'b1, 3'd5);
    serve(1, 0, K_NONE);
    @(negedge clk);
    abort = 1'b1;
    cert_failed = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    cert_failed = 1'b0;
    check("abort_priority_code", int'(fail_code), 5);
    repeat (3) @(negedge clk);

    // handshake timeout: init_ack_out never arrives
    start_flow(2'd1);
    @(negedge clk);
    check("req_one_cycle", int'(init_req), 0);
    check("type_hold_wait_sent", int'(type_of_request), 2);
    push_verdict(1'b0, 1'b1, 3'd6);
    wait_verdict(100);
    repeat (3) @(negedge clk);

    // asynchronous reset during WAIT_SENT, then a clean flow with a stray start
    start_flow(2'd2);
    @(negedge clk);
    reset = 1'b0;
    #1;
    check("reset_mid_outputs", int'({init_req, type_of_request, slot, init_ack_in, error_busy,
          busy, auth_pass, auth_fail, fail_code, retry_count}), 0);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    current_timeout = 32'd100;
    start_flow(2'd1);
    @(negedge clk);
    slot_sel = 2'd3;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("start_ignored_slot", int'(slot), 1);
    check("start_ignored_type", int'(type_of_request), 2);
    push_req(2'd3, 2'd1, 3'd0);
    serve(1, 2, K_RESP);
    step_ok(2'd1, K_CERT);
    final_ok(K_RESP);
    repeat (4) @(negedge clk);

    check("req_queue_drained", req_q.size(), 0);
    check("verdict_queue_drained", verdict_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
